pt2272_output_latch: RTL and testbench

Output-conditioning stage directly downstream of `decodificador_pt2272`: consumes its per-frame data word `D` and `dv` strobe and produces the user-facing data outputs and valid-transmission flag. Filters spurious frames by requiring CONFIRM consecutive identical words. Generates a timeout-driven VT signal. Supports momentary mode (outputs clear on timeout) and latched mode (outputs hold until a new confirmed word), mirroring the PT2272-M4/L4 variants.

---
 rtl/pt2272_output_latch_if.sv | 12 +
 rtl/pt2272_output_latch.sv | 106 ++++++++++
 tb/tb_pt2272_output_latch.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/pt2272_output_latch_if.sv
// Bundles the decoder-side frame inputs and the user-facing outputs of the PT2272 output latch.
interface pt2272_output_latch_if;
  logic [3:0] D_in;
  logic       dv_in;
  logic       latch_mode;
  logic [3:0] D_out;
  logic       vt;
  logic       new_code;

  modport master (output D_in, dv_in, latch_mode, input D_out, vt, new_code);
  modport slave  (input D_in, dv_in, latch_mode, output D_out, vt, new_code);
endinterface

// File: rtl/pt2272_output_latch.sv
// Confirms CONFIRM identical decoded words before committing them, drives VT from a frame timeout.
// One registered stage: D_out/vt/new_code change right after the confirming or expiring edge.
module pt2272_output_latch #(
  parameter int CONFIRM = 2,
  parameter int TIMEOUT = 200000
) (
  input logic                   clk,
  input logic                   reset,
  pt2272_output_latch_if.slave  bus
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [3:0]    CONF = 4'(CONFIRM);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, CONFIRMING, ACTIVE} state_t;

  state_t        state, state_nxt;
  logic [3:0]    cand, cand_nxt, cand_upd;
  logic [3:0]    cnt, cnt_nxt, cnt_upd;
  logic [TW-1:0] timer, timer_nxt;
  logic [3:0]    d_out, d_out_nxt;
  logic          new_code, new_code_nxt;
  logic          vt;
  logic          commit, expired;

  // Candidate tracking is independent of state; commit/expiry decisions build on it.
  always_comb begin
    cand_upd = cand;
    cnt_upd  = cnt;
    if (bus.dv_in) begin
      if (bus.D_in == cand && cnt != 4'd0) begin
        cnt_upd = (cnt < CONF) ? cnt + 4'd1 : CONF;
      end else begin
        cand_upd = bus.D_in;
        cnt_upd  = 4'd1;
      end
    end
    commit  = bus.dv_in && (cnt_upd == CONF) && (state != ACTIVE || cand_upd != d_out);
    expired = !bus.dv_in && (timer == TMAX) && (state != IDLE);
  end

  always_comb begin
    state_nxt    = state;
    cand_nxt     = cand_upd;
    cnt_nxt      = cnt_upd;
    d_out_nxt    = d_out;
    new_code_nxt = 1'b0;
    if (bus.dv_in)
      timer_nxt = '0;
    else if (timer == TMAX)
      timer_nxt = timer;
    else
      timer_nxt = timer + TW'(1);

    case (state)
      IDLE: begin
        if (bus.dv_in) state_nxt = CONFIRMING;
      end
      CONFIRMING: begin
        if (expired) begin
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
        end
      end
      ACTIVE: begin
        if (expired) begin
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
          if (!bus.latch_mode) d_out_nxt = 4'd0;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // commit and expiry are mutually exclusive: commit needs dv_in, expiry needs its absence
    if (commit) begin
      d_out_nxt    = cand_upd;
      new_code_nxt = 1'b1;
      state_nxt    = ACTIVE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cand     <= 4'd0;
      cnt      <= 4'd0;
      timer    <= '0;
      d_out    <= 4'd0;
      new_code <= 1'b0;
      vt       <= 1'b0;
    end else begin
      state    <= state_nxt;
      cand     <= cand_nxt;
      cnt      <= cnt_nxt;
      timer    <= timer_nxt;
      d_out    <= d_out_nxt;
      new_code <= new_code_nxt;
      vt       <= (state_nxt == ACTIVE);
    end
  end

  assign bus.D_out    = d_out;
  assign bus.vt       = vt;
  assign bus.new_code = new_code;
endmodule

// File: tb/tb_pt2272_output_latch.sv
// Directed bench: two DUTs (CONFIRM=2 and CONFIRM=1) share one stimulus stream and are checked against a frame-history model.
module tb_pt2272_output_latch;
  localparam int TMO = 50;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;

  always #5 clk = ~clk;

  pt2272_output_latch_if b0 ();
  pt2272_output_latch_if b1 ();

  assign b1.D_in       = b0.D_in;
  assign b1.dv_in      = b0.dv_in;
  assign b1.latch_mode = b0.latch_mode;

  pt2272_output_latch #(.CONFIRM(2), .TIMEOUT(TMO)) u0 (.clk(clk), .reset(reset), .bus(b0));
  pt2272_output_latch #(.CONFIRM(1), .TIMEOUT(TMO)) u1 (.clk(clk), .reset(reset), .bus(b1));

  // Model: length of the trailing run of identical frames, and elapsed cycles since the last frame.
  typedef struct packed {
    int         run_len;
    logic [3:0] run_word;
    int         since;
    logic       engaged;
    logic       active;
    logic [3:0] dout;
    logic       nc;
  } model_t;

  model_t m0 = '0;
  model_t m1 = '0;

  function automatic model_t step(model_t m_in, int confirm, logic rst, logic dv,
                                  logic [3:0] d, logic lm);
    model_t m = m_in;
    m.nc = 1'b0;
    if (rst) begin
      m = '0;
    end else if (dv) begin
      if (m.run_len > 0 && d == m.run_word) m.run_len = m.run_len + 1;
      else begin
        m.run_word = d;
        m.run_len  = 1;
      end
      m.since   = 0;
      m.engaged = 1'b1;
      if (m.run_len >= confirm && (!m.active || d != m.dout)) begin
        m.dout   = d;
        m.nc     = 1'b1;
        m.active = 1'b1;
      end
    end else begin
      m.since = m.since + 1;
      if (m.engaged && m.since == TMO + 1) begin
        m.engaged = 1'b0;
        m.run_len = 0;
        if (m.active && !lm) m.dout = 4'd0;
        m.active = 1'b0;
      end
    end
    return m;
  endfunction

  always @(posedge clk) begin
    m0 = step(m0, 2, reset, b0.dv_in, b0.D_in, b0.latch_mode);
    m1 = step(m1, 1, reset, b0.dv_in, b0.D_in, b0.latch_mode);
  end

  task automatic chk(string name, logic [5:0] act, logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got {vt,new_code,D_out}=%b required %b at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_c2", {b0.vt, b0.new_code, b0.D_out}, {m0.active, m0.nc, m0.dout});
      chk("model_c1", {b1.vt, b1.new_code, b1.D_out}, {m1.active, m1.nc, m1.dout});
    end
  end

  task automatic frame(input logic [3:0] d);
    @(negedge clk);
    b0.dv_in = 1'b1;
    b0.D_in  = d;
    @(negedge clk);
    b0.dv_in = 1'b0;
  endtask

  task automatic burst(input logic [3:0] d, input int n);
    @(negedge clk);
    b0.dv_in = 1'b1;
    b0.D_in  = d;
    repeat (n) @(negedge clk);
    b0.dv_in = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    b0.dv_in      = 1'b0;
    b0.D_in       = 4'd0;
    b0.latch_mode = 1'b0;
    gap(2);
    reset = 1'b0;
    chk("reset_c2", {b0.vt, b0.new_code, b0.D_out}, 6'b00_0000);
    chk("reset_c1", {b1.vt, b1.new_code, b1.D_out}, 6'b00_0000);
    chk_en = 1'b1;

    // momentary commit and timeout
    frame(4'b1010);
    chk("single_no_commit", {b0.vt, b0.new_code, b0.D_out}, 6'b00_0000);
    chk("confirm1_first",   {b1.vt, b1.new_code, b1.D_out}, 6'b11_1010);
    gap(18);
    frame(4'b1010);
    chk("commit",           {b0.vt, b0.new_code, b0.D_out}, 6'b11_1010);
    gap(1);
    chk("nc_one_cycle",     {b0.vt, b0.new_code, b0.D_out}, 6'b10_1010);
    gap(49);
    chk("before_expiry",    {b0.vt, b0.new_code, b0.D_out}, 6'b10_1010);
    gap(1);
    chk("momentary_clear",  {b0.vt, b0.new_code, b0.D_out}, 6'b00_0000);

    // latched hold
    b0.latch_mode = 1'b1;
    frame(4'b1010);
    gap(18);
    frame(4'b1010);
    gap(51);
    chk("latched_hold",     {b0.vt, b0.new_code, b0.D_out}, 6'b00_1010);
    frame(4'b1111);
    chk("latched_single",   {b0.vt, b0.new_code, b0.D_out}, 6'b00_1010);
    frame(4'b1111);
    chk("latched_new",      {b0.vt, b0.new_code, b0.D_out}, 6'b11_1111);
    gap(51);
    b0.latch_mode = 1'b0;

    // glitch rejection
    gap(8); frame(4'b1010);
    gap(8); frame(4'b0101);
    gap(8); frame(4'b1010);
    chk("glitch_reject",    {b0.vt, b0.new_code, b0.D_out}, 6'b00_1111);
    gap(8); frame(4'b1010);
    chk("glitch_commit",    {b0.vt, b0.new_code, b0.D_out}, 6'b11_1010);

    // code change while active
    frame(4'b1111);
    chk("change_pending",   {b0.vt, b0.new_code, b0.D_out}, 6'b10_1010);
    frame(4'b1111);
    chk("change_commit",    {b0.vt, b0.new_code, b0.D_out}, 6'b11_1111);
    gap(1);

    // repeat frame on exactly the expiry edge
    gap(48);
    frame(4'b1111);
    chk("dv_wins_expiry",   {b0.vt, b0.new_code, b0.D_out}, 6'b10_1111);
    gap(50);
    chk("extended_alive",   {b0.vt, b0.new_code, b0.D_out}, 6'b10_1111);
    gap(1);
    chk("extended_expiry",  {b0.vt, b0.new_code, b0.D_out}, 6'b00_0000);
    frame(4'b1111);
    frame(4'b1111);
    chk("recommit_after_idle", {b0.vt, b0.new_code, b0.D_out}, 6'b11_1111);

    // reset while active
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("reset_active",     {b0.vt, b0.new_code, b0.D_out}, 6'b00_0000);
    frame(4'b0110);
    chk("post_reset_single", {b0.vt, b0.new_code, b0.D_out}, 6'b00_0000);
    chk("post_reset_c1",    {b1.vt, b1.new_code, b1.D_out}, 6'b11_0110);
    frame(4'b0110);
    chk("post_reset_commit", {b0.vt, b0.new_code, b0.D_out}, 6'b11_0110);

    // multi-cycle dv_in counts as consecutive frames
    burst(4'b0101, 2);
    chk("burst_commit",     {b0.vt, b0.new_code, b0.D_out}, 6'b11_0101);

    // confirming expires back to idle and forgets the count
    gap(52);
    frame(4'b0011);
    gap(60);
    frame(4'b0011);
    chk("confirm_expired",  {b0.vt, b0.new_code, b0.D_out}, 6'b00_0000);
    frame(4'b0011);
    chk("confirm_after_exp", {b0.vt, b0.new_code, b0.D_out}, 6'b11_0011);
    gap(3);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
